mandel_iter_ctrl: RTL and testbench
===================================

Name: mandel_iter_ctrl

Overview:
- Per-pixel Mandelbrot iteration sequencer. It accepts one point c = (cr, ci) and iterates z <- z^2 + c from z = 0 until |z|^2 > 4.0 or until max_iter iterations complete.
- Shares a single fixed-point mult instance across the three products needed per iteration (x*x, y*y, x*y). It uses saturating add/sub for the update.
- Sits between the pixel scanner (upstream) and the colour mapper (downstream). Valid/ready handshake on both sides.

Parameters:
- WIDTH, 64, total fixed-point word width (two's complement).
- INT_WIDTH, 32, integer bits including sign.
- FRAC_WIDTH, 32, fraction bits; WIDTH = INT_WIDTH + FRAC_WIDTH.
- ITER_WIDTH, 16, width of the iteration limit and count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers a point.
- in_ready  output  1  controller can accept a point.
- cr  input  WIDTH  real part of c.
- ci  input  WIDTH  imaginary part of c.
- max_iter  input  ITER_WIDTH  iteration limit, sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- iter_count  output  ITER_WIDTH  iterations completed before escape or limit.
- escaped  output  1  1 = escaped, 0 = hit limit.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset:
  - state=IDLE; in_ready=1; out_valid=0; iter_count=0; escaped=0.
  - Internal x, y, cr, ci, count, limit are all 0. mult go=0.
  - Reset takes effect on any cycle and aborts an in-flight pixel; no result is emitted for it.
- States: IDLE, MXX, MYY, MXY, UPDATE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch cr, ci, max_iter; x=y=0; count=0.
  - Next state is DONE (escaped=0, iter_count=0) if max_iter==0, else MXX.
  - in_ready=0 in all other states.
- MUL states (MXX, MYY, MXY):
  - 5 cycles each.
  - Cycle 0 is the flush cycle: go=0, which clears the mult pipeline. mult done is ignored in this cycle.
  - Cycles 1..4: go=1, operands held stable from registers.
  - mult done rises in cycle 4. The product is captured on that edge and the FSM advances.
  - Sign handling (the mult is unsigned):
    - Operands fed as |x|, |y|.
    - |most-negative| saturates to the max positive value.
    - x*y result is negated when sign(x) != sign(y).
  - Capture targets: MXX -> x2, MYY -> y2, MXY -> xy.
- UPDATE (1 cycle), all adds saturating, signed:
  - mag = x2 + y2.
  - If mag > 4.0 (4 << FRAC_WIDTH): escaped=1, iter_count=count, go to DONE.
  - Else:
    - x <= (x2 - y2) + cr.
    - y <= (xy + xy) + ci.
    - count <= count + 1.
  - If count+1 == limit: escaped=0, iter_count=count+1, go to DONE; else go to MXX.
  - mag == 4.0 exactly is NOT escape.
- Per-iteration latency: 16 cycles.
  - out_valid rises exactly 16*k cycles after the accepting edge.
  - k = iter_count+1 if escaped, else iter_count.
- DONE:
  - out_valid=1; iter_count and escaped held stable until out_ready.
  - Handshake edge: out_valid=0, go to IDLE.
  - A new point can be accepted no earlier than the cycle after the result handshake.
- Saturation: overflow clamps to {0,1..1}; underflow clamps to {1..1}. This matches the existing add/sub semantics.

Decomposition:
- Package mandel_pkg:
  - state enum.
  - Constant ESCAPE_THRESH = 4 << FRAC_WIDTH.
  - Functions sat_add, sat_sub, fp_abs, fp_neg, with WIDTH-parameterised logic.
- Sub-modules:
  - Instantiates the existing mult once (shared).
  - Saturating add/sub are implemented via the existing add/sub modules or the package functions.
  - No new sub-module is needed.

Test Plan:
- c=(0,0), max_iter=10 -> escaped=0, iter_count=10, out_valid exactly 160 cycles after accept.
- c=(3.0,0), max_iter=50 -> iteration 1 gives z=3; iteration 2 gives mag=9 -> escaped=1, iter_count=1, out_valid 32 cycles after accept.
- c=(-2.0,0), max_iter=20 -> z settles at 2, mag=4.0 is not escape -> escaped=0, iter_count=20.
- c=(0,1.0), max_iter=8 -> orbit i, -1+i, -i, -1+i... exercises a negative x*y -> escaped=0, iter_count=8. Probe confirms x=-1.0, y=1.0 after update 2.
- max_iter=0, any c -> DONE next cycle, escaped=0, iter_count=0. Hold out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0 throughout.
- Assert reset for one cycle mid-MXY of a long pixel -> next cycle in_ready=1, out_valid=0. A following c=(3.0,0) returns iter_count=1, escaped=1 with nominal latency.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types, constants and saturating fixed-point helpers for the
// Mandelbrot iteration controller.
//   state_e        : controller states
//   fp_t           : signed fixed-point word (INT_WIDTH.FRAC_WIDTH)
//   ESCAPE_THRESH  : |z|^2 escape bound (4.0)
//   sat_add/sat_sub/fp_abs/fp_neg : saturating arithmetic on fp_t
package mandel_pkg;

  localparam int unsigned WIDTH      = 64;
  localparam int unsigned INT_WIDTH  = 32;
  localparam int unsigned FRAC_WIDTH = WIDTH - INT_WIDTH;
  localparam int unsigned ITER_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MXX    = 3'd1,
    ST_MYY    = 3'd2,
    ST_MXY    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef logic signed [WIDTH-1:0] fp_t;

  localparam fp_t FP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam fp_t FP_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Underflow clamps to all-ones, matching the legacy add/sub blocks.
  localparam fp_t FP_UFL = {WIDTH{1'b1}};

  localparam fp_t ESCAPE_THRESH = fp_t'(64'd4 << FRAC_WIDTH);

  function automatic fp_t sat_add(input fp_t a, input fp_t b);
    fp_t s;
    s = a + b;
    if ((a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]))
      s = a[WIDTH-1] ? FP_UFL : FP_MAX;
    return s;
  endfunction

  function automatic fp_t sat_sub(input fp_t a, input fp_t b);
    fp_t d;
    d = a - b;
    if ((a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]))
      d = a[WIDTH-1] ? FP_UFL : FP_MAX;
    return d;
  endfunction

  // |a|, with |most-negative| clamped to the largest positive value.
  function automatic fp_t fp_abs(input fp_t a);
    fp_t r;
    if (a == FP_MIN)      r = FP_MAX;
    else if (a[WIDTH-1])  r = -a;
    else                  r = a;
    return r;
  endfunction

  function automatic fp_t fp_neg(input fp_t a);
    fp_t r;
    if (a == FP_MIN) r = FP_MAX;
    else             r = -a;
    return r;
  endfunction

endpackage

// File: rtl/mandel_iter_ctrl_mult.sv
// Pipelined unsigned fixed-point multiplier shared by all three products.
// Holding go_i low for a cycle flushes the pipeline; with go_i held high and
// operands stable, done_o rises on the fourth go cycle together with p_o.
//   clk_i, reset_i : clock, synchronous active-high reset
//   go_i           : run (1) / flush (0)
//   a_i, b_i       : unsigned operands (FW fraction bits)
//   done_o, p_o    : product valid, product (saturated to signed max)
module mandel_iter_ctrl_mult #(
  parameter int unsigned W  = 64,
  parameter int unsigned FW = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         go_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] p_o
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] full_q;
  logic [PW-1:0] shifted_c;
  logic [W-1:0]  scaled_d;
  logic [W-1:0]  scaled_q;
  logic [W-1:0]  p_q;
  logic [2:0]    vld_q;

  // Drop fraction bits; anything beyond the signed range clamps to max.
  assign shifted_c = full_q >> FW;

  always_comb begin : scale_comb
    scaled_d = shifted_c[W-1:0];
    if (|shifted_c[PW-1:W-1])
      scaled_d = {1'b0, {(W-1){1'b1}}};
  end

  always_ff @(posedge clk_i) begin : pipe_ff
    if (reset_i || !go_i) begin
      vld_q    <= '0;
      full_q   <= '0;
      scaled_q <= '0;
      p_q      <= '0;
    end else begin
      vld_q    <= {vld_q[1:0], 1'b1};
      full_q   <= PW'(a_i) * PW'(b_i);
      scaled_q <= scaled_d;
      p_q      <= scaled_q;
    end
  end

  assign done_o = vld_q[2];
  assign p_o    = p_q;

endmodule

// File: rtl/mandel_iter_ctrl.sv
// Per-pixel Mandelbrot iteration sequencer: iterates z <- z^2 + c from z = 0
// until |z|^2 > 4.0 or max_iter iterations, using one shared multiplier.
//   clk_i, reset_i         : clock, synchronous active-high reset
//   in_valid_i/in_ready_o  : point handshake (cr_i, ci_i, max_iter_i)
//   out_valid_o/out_ready_i: result handshake (iter_count_o, escaped_o)
module mandel_iter_ctrl
  import mandel_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      cr_i,
  input  logic [WIDTH-1:0]      ci_i,
  input  logic [ITER_WIDTH-1:0] max_iter_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ITER_WIDTH-1:0] iter_count_o,
  output logic                  escaped_o
);

  state_e state_q, state_d;
  logic [2:0] cyc_q, cyc_d;
  fp_t x_q, x_d, y_q, y_d, cr_q, cr_d, ci_q, ci_d;
  fp_t x2_q, x2_d, y2_q, y2_d, xy_q, xy_d;
  logic [ITER_WIDTH-1:0] count_q, count_d, limit_q, limit_d;
  logic [ITER_WIDTH-1:0] iter_count_q, iter_count_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic escaped_q, escaped_d;

  logic                  is_mul_c, go_c, mul_cap_c, escape_c, last_c;
  logic [WIDTH-1:0]      op_a_c, op_b_c, mul_p;
  logic                  mul_done;
  fp_t                   abs_x_c, abs_y_c, mag_c;
  logic [ITER_WIDTH-1:0] count_inc_c;

  assign is_mul_c    = (state_q == ST_MXX) || (state_q == ST_MYY) || (state_q == ST_MXY);
  // Cycle 0 of each multiply state flushes the pipeline.
  assign go_c        = is_mul_c && (cyc_q != 3'd0);
  assign mul_cap_c   = go_c && mul_done;
  assign abs_x_c     = fp_abs(x_q);
  assign abs_y_c     = fp_abs(y_q);
  assign mag_c       = sat_add(x2_q, y2_q);
  assign escape_c    = mag_c > ESCAPE_THRESH;
  assign count_inc_c = count_q + ITER_WIDTH'(1);
  assign last_c      = (count_inc_c == limit_q);

  // Operand steering into the shared multiplier.
  always_comb begin : op_comb
    op_a_c = abs_x_c;
    op_b_c = abs_x_c;
    if (state_q == ST_MYY) begin
      op_a_c = abs_y_c;
      op_b_c = abs_y_c;
    end else if (state_q == ST_MXY) begin
      op_b_c = abs_y_c;
    end
  end

  mandel_iter_ctrl_mult #(
    .W  (WIDTH),
    .FW (FRAC_WIDTH)
  ) u_mult (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .go_i    (go_c),
    .a_i     (op_a_c),
    .b_i     (op_b_c),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  // State register.
  always_ff @(posedge clk_i) begin : state_ff
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid_i) state_d = (max_iter_i == '0) ? ST_DONE : ST_MXX;
      ST_MXX:    if (mul_cap_c) state_d = ST_MYY;
      ST_MYY:    if (mul_cap_c) state_d = ST_MXY;
      ST_MXY:    if (mul_cap_c) state_d = ST_UPDATE;
      ST_UPDATE: state_d = (escape_c || last_c) ? ST_DONE : ST_MXX;
      ST_DONE:   if (out_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin : output_comb
    cyc_d        = cyc_q;
    x_d          = x_q;
    y_d          = y_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    x2_d         = x2_q;
    y2_d         = y2_q;
    xy_d         = xy_q;
    count_d      = count_q;
    limit_d      = limit_q;
    iter_count_d = iter_count_q;
    escaped_d    = escaped_q;
    out_valid_d  = (state_d == ST_DONE);
    in_ready_d   = (state_d == ST_IDLE);

    if (state_d != state_q)
      cyc_d = '0;
    else if (is_mul_c && (cyc_q != 3'd4))
      cyc_d = cyc_q + 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          cr_d    = fp_t'(cr_i);
          ci_d    = fp_t'(ci_i);
          limit_d = max_iter_i;
          x_d     = '0;
          y_d     = '0;
          count_d = '0;
          if (max_iter_i == '0) begin
            iter_count_d = '0;
            escaped_d    = 1'b0;
          end
        end
      end
      ST_MXX: if (mul_cap_c) x2_d = fp_t'(mul_p);
      ST_MYY: if (mul_cap_c) y2_d = fp_t'(mul_p);
      ST_MXY: begin
        // Magnitudes were multiplied; restore the sign of x*y.
        if (mul_cap_c)
          xy_d = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) ? fp_neg(fp_t'(mul_p)) : fp_t'(mul_p);
      end
      ST_UPDATE: begin
        if (escape_c) begin
          escaped_d    = 1'b1;
          iter_count_d = count_q;
        end else begin
          x_d     = sat_add(sat_sub(x2_q, y2_q), cr_q);
          y_d     = sat_add(sat_add(xy_q, xy_q), ci_q);
          count_d = count_inc_c;
          if (last_c) begin
            escaped_d    = 1'b0;
            iter_count_d = count_inc_c;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin : dp_ff
    if (reset_i) begin
      cyc_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      xy_q         <= '0;
      count_q      <= '0;
      limit_q      <= '0;
      iter_count_q <= '0;
      escaped_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      cyc_q        <= cyc_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      xy_q         <= xy_d;
      count_q      <= count_d;
      limit_q      <= limit_d;
      iter_count_q <= iter_count_d;
      escaped_q    <= escaped_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign iter_count_o = iter_count_q;
  assign escaped_o    = escaped_q;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Self-checking bench for mandel_iter_ctrl: directed scenarios plus random
// points checked against an arithmetic reference of the escape iteration.
module tb_mandel_iter_ctrl;

  typedef logic signed [63:0] fx_t;
  localparam fx_t ONE    = fx_t'(64'd1 << 32);
  localparam fx_t THRESH = fx_t'(64'd4 << 32);
  localparam fx_t MAXP   = fx_t'(64'h7FFF_FFFF_FFFF_FFFF);
  localparam fx_t MINN   = fx_t'(64'h8000_0000_0000_0000);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] cr = '0;
  logic [63:0] ci = '0;
  logic [15:0] max_iter = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] iter_count;
  logic        escaped;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mandel_iter_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .cr_i         (cr),
    .ci_i         (ci),
    .max_iter_i   (max_iter),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .iter_count_o (iter_count),
    .escaped_o    (escaped)
  );

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- reference arithmetic ----------------
  function automatic fx_t m_clamp(input logic signed [65:0] v);
    logic signed [65:0] hi, lo;
    hi = $signed({2'b00, MAXP});
    lo = $signed({2'b11, MINN});
    if (v > hi) return MAXP;
    if (v < lo) return fx_t'(-1);
    return fx_t'(v[63:0]);
  endfunction

  function automatic fx_t m_add(input fx_t a, input fx_t b);
    return m_clamp($signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}));
  endfunction

  function automatic fx_t m_sub(input fx_t a, input fx_t b);
    return m_clamp($signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}));
  endfunction

  function automatic logic [63:0] m_mag(input fx_t a);
    if (a == MINN) return 64'(MAXP);
    return (a < 0) ? 64'(-a) : 64'(a);
  endfunction

  function automatic fx_t m_mul(input fx_t a, input fx_t b);
    logic [127:0] p;
    fx_t r;
    p = ({64'd0, m_mag(a)} * {64'd0, m_mag(b)}) >> 32;
    r = (p > {64'd0, 64'(MAXP)}) ? MAXP : fx_t'(p[63:0]);
    if ((a < 0) != (b < 0)) r = -r;
    return r;
  endfunction

  task automatic model(input fx_t c_r, input fx_t c_i, input logic [15:0] mi,
                       output int cnt, output logic esc, output int lat);
    fx_t x, y, x2, y2, xy;
    x = 0; y = 0; cnt = 0; esc = 1'b0; lat = 0;
    if (mi == 16'd0) return;
    for (int it = 0; it < 65536; it++) begin
      x2 = m_mul(x, x);
      y2 = m_mul(y, y);
      xy = m_mul(x, y);
      if (m_add(x2, y2) > THRESH) begin
        esc = 1'b1; lat = 16 * (cnt + 1); return;
      end
      x = m_add(m_sub(x2, y2), c_r);
      y = m_add(m_add(xy, xy), c_i);
      cnt++;
      if (cnt == int'(mi)) begin
        lat = 16 * cnt; return;
      end
    end
  endtask

  // ---------------- drivers (no checking) ----------------
  task automatic drive_pixel(input fx_t c_r, input fx_t c_i, input logic [15:0] mi,
                             input int probe_at, output int lat, output logic [15:0] cnt,
                             output logic esc, output logic rdy_seen,
                             output fx_t px, output fx_t py);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    cr = 64'(c_r); ci = 64'(c_i); max_iter = mi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs after the accept to show they were latched.
    cr = {$urandom, $urandom}; ci = {$urandom, $urandom}; max_iter = 16'($urandom);
    lat = 0; rdy_seen = 1'b0; px = 0; py = 0;
    while (!out_valid && lat < 4000) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (lat == probe_at) begin
        px = dut.x_q; py = dut.y_q;
      end
    end
    if (!out_valid) lat = -1;
    if (in_ready) rdy_seen = 1'b1;
    cnt = iter_count; esc = escaped;
  endtask

  task automatic take_result(output logic ov, output logic ir);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ov = out_valid; ir = in_ready;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (iter_count !== 16'd0) begin n_bad++; $display("FAIL reset_iter_count: got %0d want 0", iter_count); end
    n_cmp++; if (escaped !== 1'b0) begin n_bad++; $display("FAIL reset_escaped: got %b want 0", escaped); end
  endtask

  task automatic test_origin;
    int lat; logic [15:0] cnt; logic esc, rs, ov, ir; fx_t px, py;
    drive_pixel(0, 0, 16'd10, 0, lat, cnt, esc, rs, px, py);
    n_cmp++; if (lat != 160) begin n_bad++; $display("FAIL origin_latency: got %0d want 160", lat); end
    n_cmp++; if (cnt !== 16'd10) begin n_bad++; $display("FAIL origin_count: got %0d want 10", cnt); end
    n_cmp++; if (esc !== 1'b0) begin n_bad++; $display("FAIL origin_escaped: got %b want 0", esc); end
    n_cmp++; if (rs !== 1'b0) begin n_bad++; $display("FAIL origin_busy_ready: in_ready seen %b want 0", rs); end
    take_result(ov, ir);
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL origin_out_valid_drop: got %b want 0", ov); end
    n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL origin_in_ready_back: got %b want 1", ir); end
  endtask

  task automatic test_fast_escape;
    int lat; logic [15:0] cnt; logic esc, rs, ov, ir; fx_t px, py;
    drive_pixel(3 * ONE, 0, 16'd50, 0, lat, cnt, esc, rs, px, py);
    n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL escape_latency: got %0d want 32", lat); end
    n_cmp++; if (cnt !== 16'd1) begin n_bad++; $display("FAIL escape_count: got %0d want 1", cnt); end
    n_cmp++; if (esc !== 1'b1) begin n_bad++; $display("FAIL escape_flag: got %b want 1", esc); end
    take_result(ov, ir);
  endtask

  task automatic test_boundary;
    int lat; logic [15:0] cnt; logic esc, rs, ov, ir; fx_t px, py;
    drive_pixel(-2 * ONE, 0, 16'd20, 0, lat, cnt, esc, rs, px, py);
    n_cmp++; if (cnt !== 16'd20) begin n_bad++; $display("FAIL boundary_count: got %0d want 20", cnt); end
    n_cmp++; if (esc !== 1'b0) begin n_bad++; $display("FAIL boundary_escaped: got %b want 0", esc); end
    n_cmp++; if (lat != 320) begin n_bad++; $display("FAIL boundary_latency: got %0d want 320", lat); end
    take_result(ov, ir);
  endtask

  task automatic test_neg_xy;
    int lat; logic [15:0] cnt; logic esc, rs, ov, ir; fx_t px, py;
    drive_pixel(0, ONE, 16'd8, 32, lat, cnt, esc, rs, px, py);
    n_cmp++; if (px !== -ONE) begin n_bad++; $display("FAIL negxy_probe_x: got %h want %h", px, -ONE); end
    n_cmp++; if (py !== ONE) begin n_bad++; $display("FAIL negxy_probe_y: got %h want %h", py, ONE); end
    n_cmp++; if (cnt !== 16'd8) begin n_bad++; $display("FAIL negxy_count: got %0d want 8", cnt); end
    n_cmp++; if (esc !== 1'b0) begin n_bad++; $display("FAIL negxy_escaped: got %b want 0", esc); end
    n_cmp++; if (lat != 128) begin n_bad++; $display("FAIL negxy_latency: got %0d want 128", lat); end
    take_result(ov, ir);
  endtask

  task automatic test_zero_limit;
    int lat; logic [15:0] cnt; logic esc, rs, ov, ir; fx_t px, py;
    drive_pixel(fx_t'({$urandom, $urandom}), ONE, 16'd0, 0, lat, cnt, esc, rs, px, py);
    n_cmp++; if (lat != 0) begin n_bad++; $display("FAIL zero_latency: got %0d want 0", lat); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || iter_count !== 16'd0 || escaped !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_hold[%0d]: ov=%b cnt=%0d esc=%b ir=%b want ov=1 cnt=0 esc=0 ir=0",
                 i, out_valid, iter_count, escaped, in_ready);
      end
      @(posedge clk); #1;
    end
    take_result(ov, ir);
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL zero_out_valid_drop: got %b want 0", ov); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] cnt; logic esc, rs; fx_t px, py;
    cr = '0; ci = '0; max_iter = 16'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    drive_pixel(3 * ONE, 0, 16'd50, 0, lat, cnt, esc, rs, px, py);
    n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL midreset_latency: got %0d want 32", lat); end
    n_cmp++; if (cnt !== 16'd1 || esc !== 1'b1) begin n_bad++; $display("FAIL midreset_result: got cnt=%0d esc=%b want cnt=1 esc=1", cnt, esc); end
    begin logic ov, ir; take_result(ov, ir); end
  endtask

  task automatic test_back_to_back;
    int lat, m_cnt, m_lat; logic [15:0] cnt, mi; logic esc, m_esc, rs, ov, ir; fx_t px, py, c_r, c_i;
    for (int k = 0; k < 14; k++) begin
      c_r = fx_t'((longint'($urandom_range(0, 327680)) - 163840) <<< 16);
      c_i = fx_t'((longint'($urandom_range(0, 327680)) - 163840) <<< 16);
      mi  = 16'($urandom_range(1, 24));
      model(c_r, c_i, mi, m_cnt, m_esc, m_lat);
      drive_pixel(c_r, c_i, mi, 0, lat, cnt, esc, rs, px, py);
      n_cmp++;
      if (cnt !== 16'(m_cnt) || esc !== m_esc || lat != m_lat) begin
        n_bad++;
        $display("FAIL rand[%0d] c=(%h,%h) max=%0d: got cnt=%0d esc=%b lat=%0d want cnt=%0d esc=%b lat=%0d",
                 k, c_r, c_i, mi, cnt, esc, lat, m_cnt, m_esc, m_lat);
      end
      take_result(ov, ir);
      n_cmp++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
        n_bad++;
        $display("FAIL rand_handshake[%0d]: got ov=%b ir=%b want ov=0 ir=1", k, ov, ir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_origin();
    test_fast_escape();
    test_boundary();
    test_neg_xy();
    test_zero_limit();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
